// File: rtl/friscv_rd_wr_arbiter_pkg.sv
// Shared friscv header package: rd write-port widths, the rd-entry layout
// and the round-robin pick helper reused by the processing stage.
`ifndef FRISCV_H_RD_ENTRY_MACROS
`define FRISCV_H_RD_ENTRY_MACROS
`define FRISCV_RD_STRB_W(xlen) ((xlen)/8)
`define FRISCV_RD_ENTRY_T(xlen) struct packed { logic [friscv_h::RD_W-1:0] addr; logic [(xlen)-1:0] val; logic [`FRISCV_RD_STRB_W(xlen)-1:0] strb; }
`endif

package friscv_h;

    localparam int RD_W        = 5;
    localparam int MAX_NB_UNIT = 4;

    // First requester after 'last', wrapping modulo n; -1 when nobody asks.
    function automatic int rr_pick(input int last, input logic [MAX_NB_UNIT-1:0] req, input int n);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= MAX_NB_UNIT; k++) begin
            idx = (last + k) % n;
            if ((k <= n) && (pick < 0) && req[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/friscv_rd_wr_arbiter_if.sv
// Unit write ports and the single register-file write port of the rd arbiter.
interface friscv_rd_wr_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NB_UNIT = 3
);
    import friscv_h::*;

    logic [NB_UNIT-1:0]          unit_rd_wr;
    logic [NB_UNIT*RD_W-1:0]     unit_rd_addr;
    logic [NB_UNIT*XLEN-1:0]     unit_rd_val;
    logic [NB_UNIT*XLEN/8-1:0]   unit_rd_strb;
    logic                        rf_wr;
    logic                        rf_ready;
    logic [RD_W-1:0]             rf_addr;
    logic [XLEN-1:0]             rf_val;
    logic [XLEN/8-1:0]           rf_strb;

    modport master (
        output unit_rd_wr, unit_rd_addr, unit_rd_val, unit_rd_strb, rf_ready,
        input  rf_wr, rf_addr, rf_val, rf_strb
    );

    modport slave (
        input  unit_rd_wr, unit_rd_addr, unit_rd_val, unit_rd_strb, rf_ready,
        output rf_wr, rf_addr, rf_val, rf_strb
    );

endinterface

// File: rtl/friscv_rd_wr_arbiter_fifo.sv
// Per-unit rd write FIFO; also exposes every slot's valid/addr so the
// arbiter can tell which registers still have a write in flight.
module friscv_rd_fifo
    import friscv_h::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
)(
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [RD_W-1:0]              push_addr,
    input  logic [XLEN-1:0]              push_val,
    input  logic [XLEN/8-1:0]            push_strb,
    output logic                         full,
    output logic                         empty,
    output logic [RD_W-1:0]              head_addr,
    output logic [XLEN-1:0]              head_val,
    output logic [XLEN/8-1:0]            head_strb,
    output logic [FIFO_DEPTH-1:0]        ent_valid,
    output logic [FIFO_DEPTH*RD_W-1:0]   ent_addr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef `FRISCV_RD_ENTRY_T(XLEN) rd_entry_t;

    rd_entry_t   mem_q [FIFO_DEPTH];
    rd_entry_t   mem_d [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_s;
    logic [PW-1:0] offs_s;
    logic        push_ok_s;
    logic        pop_ok_s;

    // Status flags; the extra pointer bit separates full from empty.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[PW-1:0]] = '{addr: push_addr, val: push_val, strb: push_strb};
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Head entry and per-slot occupancy, slot i live when its distance from rd_ptr is below count.
    always_comb begin
        head_addr = mem_q[rd_ptr_q[PW-1:0]].addr;
        head_val  = mem_q[rd_ptr_q[PW-1:0]].val;
        head_strb = mem_q[rd_ptr_q[PW-1:0]].strb;
        count_s   = wr_ptr_q - rd_ptr_q;
        offs_s    = '0;
        ent_valid = '0;
        ent_addr  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offs_s                   = PW'(i) - rd_ptr_q[PW-1:0];
            ent_valid[i]             = ({1'b0, offs_s} < count_s);
            ent_addr[i*RD_W +: RD_W] = mem_q[i].addr;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/friscv_rd_wr_arbiter.sv
// Buffers per-unit rd writes and round-robins them onto one register-file
// write port; reports which integer registers still have a write pending.
module friscv_rd_wr_arbiter
    import friscv_h::*;
#(
    parameter int XLEN       = 32,
    parameter int NB_UNIT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_INT_REG = 32
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    friscv_rd_wr_arbiter_if.slave bus,
    output logic [NB_INT_REG-1:0] regs_sts,
    output logic [NB_UNIT-1:0]    overflow,
    output logic                  busy
);

    localparam int SW     = XLEN / 8;
    localparam int UW     = (NB_UNIT > 1) ? $clog2(NB_UNIT) : 1;
    localparam int RIDX_W = $clog2(NB_INT_REG);
    localparam logic [UW-1:0] LAST_RST = UW'(NB_UNIT - 1);

    logic [NB_UNIT-1:0]         push_s, pop_s, full_s, empty_s, sel_oh_s;
    logic [RD_W-1:0]            head_addr_s [NB_UNIT];
    logic [XLEN-1:0]            head_val_s  [NB_UNIT];
    logic [SW-1:0]              head_strb_s [NB_UNIT];
    logic [FIFO_DEPTH-1:0]      ent_valid_s [NB_UNIT];
    logic [FIFO_DEPTH*RD_W-1:0] ent_addr_s  [NB_UNIT];
    logic [MAX_NB_UNIT-1:0]     req_s;
    int                         pick_s;
    logic                       rf_wr_s, accept_s;
    logic [RD_W-1:0]            rf_addr_s;
    logic [XLEN-1:0]            rf_val_s;
    logic [SW-1:0]              rf_strb_s;
    logic [UW-1:0]              last_granted_q, last_granted_d;
    logic [NB_UNIT-1:0]         overflow_q, overflow_d;

    // Writes to x0 or with no strobe carry nothing and never enter a FIFO.
    always_comb begin
        push_s = '0;
        for (int u = 0; u < NB_UNIT; u++) begin
            push_s[u] = bus.unit_rd_wr[u]
                     && (bus.unit_rd_addr[u*RD_W +: RD_W] != '0)
                     && (bus.unit_rd_strb[u*SW +: SW] != '0);
        end
    end

    for (genvar u = 0; u < NB_UNIT; u++) begin : g_fifo
        friscv_rd_fifo #(
            .XLEN       (XLEN),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .srst      (srst),
            .push      (push_s[u]),
            .pop       (pop_s[u]),
            .push_addr (bus.unit_rd_addr[u*RD_W +: RD_W]),
            .push_val  (bus.unit_rd_val[u*XLEN +: XLEN]),
            .push_strb (bus.unit_rd_strb[u*SW +: SW]),
            .full      (full_s[u]),
            .empty     (empty_s[u]),
            .head_addr (head_addr_s[u]),
            .head_val  (head_val_s[u]),
            .head_strb (head_strb_s[u]),
            .ent_valid (ent_valid_s[u]),
            .ent_addr  (ent_addr_s[u])
        );
    end

    // Round-robin selection over FIFO heads; AND-OR mux keeps the datapath latch-free.
    always_comb begin
        req_s = '0;
        for (int u = 0; u < NB_UNIT; u++) begin
            req_s[u] = !empty_s[u];
        end
        pick_s    = rr_pick(int'(last_granted_q), req_s, NB_UNIT);
        rf_wr_s   = (pick_s >= 0);
        sel_oh_s  = '0;
        rf_addr_s = '0;
        rf_val_s  = '0;
        rf_strb_s = '0;
        for (int u = 0; u < NB_UNIT; u++) begin
            sel_oh_s[u] = (pick_s == u);
            rf_addr_s   = rf_addr_s | (head_addr_s[u] & {RD_W{sel_oh_s[u]}});
            rf_val_s    = rf_val_s  | (head_val_s[u]  & {XLEN{sel_oh_s[u]}});
            rf_strb_s   = rf_strb_s | (head_strb_s[u] & {SW{sel_oh_s[u]}});
        end
    end

    // Pop, pointer update and sticky overflow only move on an accepted write.
    always_comb begin
        accept_s       = rf_wr_s && bus.rf_ready;
        pop_s          = sel_oh_s & {NB_UNIT{bus.rf_ready}};
        last_granted_d = accept_s ? UW'(pick_s) : last_granted_q;
        overflow_d     = overflow_q | (push_s & full_s & ~pop_s);
    end

    // Pending-write map: a register is clear only when no live slot targets it.
    always_comb begin
        regs_sts = '1;
        for (int u = 0; u < NB_UNIT; u++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                regs_sts[ent_addr_s[u][i*RD_W +: RIDX_W]] =
                    regs_sts[ent_addr_s[u][i*RD_W +: RIDX_W]] & !ent_valid_s[u][i];
            end
        end
        regs_sts[0] = 1'b1;
    end

    assign bus.rf_wr   = rf_wr_s;
    assign bus.rf_addr = rf_addr_s;
    assign bus.rf_val  = rf_val_s;
    assign bus.rf_strb = rf_strb_s;
    assign overflow    = overflow_q;
    assign busy        = |(~empty_s);

    // Arbitration pointer and overflow flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_granted_q <= LAST_RST;
            overflow_q     <= '0;
        end else if (srst) begin
            last_granted_q <= LAST_RST;
            overflow_q     <= '0;
        end else begin
            last_granted_q <= last_granted_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule

// File: tb/tb_friscv_rd_wr_arbiter.sv
// Self-checking bench for friscv_rd_wr_arbiter: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_friscv_rd_wr_arbiter;

    localparam int XLEN  = 32;
    localparam int NU    = 3;
    localparam int DEPTH = 4;
    localparam int NREG  = 32;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] v;
        logic [3:0]  s;
    } ent_t;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            srst;
    logic [NREG-1:0] regs_sts;
    logic [NU-1:0]   overflow;
    logic            busy;

    friscv_rd_wr_arbiter_if #(.XLEN(XLEN), .NB_UNIT(NU)) bus ();

    friscv_rd_wr_arbiter #(
        .XLEN(XLEN), .NB_UNIT(NU), .FIFO_DEPTH(DEPTH), .NB_INT_REG(NREG)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .bus      (bus),
        .regs_sts (regs_sts),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per unit, round-robin pointer, sticky overflow.
    ent_t            mq [NU][$];
    int              m_last;
    logic [NU-1:0]   m_ovf;
    logic            exp_wr;
    ent_t            exp_ent;
    logic [NREG-1:0] exp_regs;
    logic            exp_busy;

    task automatic model_clear();
        for (int u = 0; u < NU; u++) mq[u].delete();
        m_last = NU - 1;
        m_ovf  = '0;
    endtask

    function automatic int model_pick();
        int p;
        p = -1;
        for (int k = 1; k <= NU; k++)
            if (p < 0 && mq[(m_last + k) % NU].size() > 0) p = (m_last + k) % NU;
        return p;
    endfunction

    task automatic model_step();
        int   p;
        ent_t e;
        if (!aresetn || srst) begin
            model_clear();
        end else begin
            p = model_pick();
            if (p >= 0 && bus.rf_ready) begin
                void'(mq[p].pop_front());
                m_last = p;
            end
            for (int u = 0; u < NU; u++) begin
                e = '{a: bus.unit_rd_addr[u*5 +: 5], v: bus.unit_rd_val[u*32 +: 32], s: bus.unit_rd_strb[u*4 +: 4]};
                if (bus.unit_rd_wr[u] && e.a != 5'd0 && e.s != 4'd0) begin
                    if (mq[u].size() < DEPTH) mq[u].push_back(e);
                    else m_ovf[u] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_eval();
        int p;
        p        = model_pick();
        exp_wr   = (p >= 0);
        exp_ent  = exp_wr ? mq[p][0] : '0;
        exp_regs = '1;
        exp_busy = 1'b0;
        for (int u = 0; u < NU; u++) begin
            if (mq[u].size() > 0) exp_busy = 1'b1;
            foreach (mq[u][i]) exp_regs[mq[u][i].a] = 1'b0;
        end
        exp_regs[0] = 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge aclk);
        #1;
        model_eval();
    endtask

    task automatic set_unit(input int u, input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
        bus.unit_rd_wr[u]          = 1'b1;
        bus.unit_rd_addr[u*5 +: 5] = a;
        bus.unit_rd_val[u*32 +: 32] = v;
        bus.unit_rd_strb[u*4 +: 4] = s;
    endtask

    task automatic clr_units();
        bus.unit_rd_wr   = '0;
        bus.unit_rd_addr = '0;
        bus.unit_rd_val  = '0;
        bus.unit_rd_strb = '0;
    endtask

    task automatic pulse_srst();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.rf_wr !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_busy: rf_wr=%b busy=%b, want 0 0", bus.rf_wr, busy);
        end
        n_checks++;
        if (regs_sts !== {NREG{1'b1}} || overflow !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sts: regs_sts=%h overflow=%b, want ffffffff 000", regs_sts, overflow);
        end
    endtask

    task automatic test_single();
        bus.rf_ready = 1'b1;
        set_unit(1, 5'd5, 32'hDEADBEEF, 4'hF);
        tick();
        clr_units();
        n_checks++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd5 || bus.rf_val !== 32'hDEADBEEF || bus.rf_strb !== 4'hF) begin
            n_fail++;
            $display("FAIL single_write: wr=%b addr=%0d val=%h strb=%h, want 1 5 deadbeef f",
                     bus.rf_wr, bus.rf_addr, bus.rf_val, bus.rf_strb);
        end
        n_checks++;
        if (regs_sts[5] !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pending: regs_sts[5]=%b busy=%b, want 0 1", regs_sts[5], busy);
        end
        tick();
        n_checks++;
        if (bus.rf_wr !== 1'b0 || regs_sts[5] !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: wr=%b regs_sts[5]=%b busy=%b, want 0 1 0", bus.rf_wr, regs_sts[5], busy);
        end
    endtask

    task automatic test_contention();
        pulse_srst();
        bus.rf_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int u = 0; u < NU; u++) set_unit(u, 5'(u + 1), $urandom, 4'hF);
            tick();
            clr_units();
            for (int g = 0; g < NU; g++) begin
                n_checks++;
                if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'(g + 1) || bus.rf_val !== exp_ent.v) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d_%0d: wr=%b addr=%0d val=%h, want 1 %0d %h",
                             b, g, bus.rf_wr, bus.rf_addr, bus.rf_val, g + 1, exp_ent.v);
                end
                tick();
            end
            n_checks++;
            if (bus.rf_wr !== 1'b0 || regs_sts !== {NREG{1'b1}}) begin
                n_fail++;
                $display("FAIL contention_drained%0d: wr=%b regs_sts=%h, want 0 ffffffff", b, bus.rf_wr, regs_sts);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] v;
        v = $urandom;
        bus.rf_ready = 1'b0;
        set_unit(0, 5'd7, v, 4'h3);
        tick();
        clr_units();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_val !== v || bus.rf_strb !== 4'h3 || regs_sts[7] !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: wr=%b addr=%0d val=%h strb=%h sts7=%b, want 1 7 %h 3 0",
                         c, bus.rf_wr, bus.rf_addr, bus.rf_val, bus.rf_strb, regs_sts[7], v);
            end
            tick();
        end
        bus.rf_ready = 1'b1;
        n_checks++;
        if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL backpressure_release: wr=%b addr=%0d, want 1 7", bus.rf_wr, bus.rf_addr);
        end
        tick();
        n_checks++;
        if (bus.rf_wr !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_once: wr=%b busy=%b, want 0 0", bus.rf_wr, busy);
        end
    endtask

    task automatic test_overflow();
        bus.rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_unit(2, 5'(10 + i), $urandom, 4'hF);
            tick();
        end
        clr_units();
        n_checks++;
        if (overflow !== 3'b100) begin
            n_fail++;
            $display("FAIL overflow_flag: overflow=%b, want 100", overflow);
        end
        bus.rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'(10 + i) || bus.rf_val !== exp_ent.v) begin
                n_fail++;
                $display("FAIL overflow_drain%0d: wr=%b addr=%0d val=%h, want 1 %0d %h",
                         i, bus.rf_wr, bus.rf_addr, bus.rf_val, 10 + i, exp_ent.v);
            end
            tick();
        end
        n_checks++;
        if (bus.rf_wr !== 1'b0 || overflow !== 3'b100 || regs_sts[14] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_after: wr=%b overflow=%b sts14=%b, want 0 100 1", bus.rf_wr, overflow, regs_sts[14]);
        end
    endtask

    task automatic test_push_while_full();
        pulse_srst();
        bus.rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_unit(0, 5'(16 + i), $urandom, 4'hF);
            tick();
        end
        bus.rf_ready = 1'b1;
        set_unit(0, 5'd20, $urandom, 4'hF);
        tick();
        clr_units();
        n_checks++;
        if (overflow !== 3'b000) begin
            n_fail++;
            $display("FAIL full_push_pop_ovf: overflow=%b, want 000", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'(17 + i)) begin
                n_fail++;
                $display("FAIL full_push_pop_drain%0d: wr=%b addr=%0d, want 1 %0d", i, bus.rf_wr, bus.rf_addr, 17 + i);
            end
            tick();
        end
        n_checks++;
        if (bus.rf_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop_end: wr=%b, want 0", bus.rf_wr);
        end
    endtask

    task automatic test_filter_reset();
        bus.rf_ready = 1'b1;
        set_unit(0, 5'd0, 32'h12345678, 4'hF);
        set_unit(1, 5'd9, 32'h9ABCDEF0, 4'h0);
        tick();
        clr_units();
        n_checks++;
        if (bus.rf_wr !== 1'b0 || regs_sts !== {NREG{1'b1}} || overflow !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL filter: wr=%b regs_sts=%h overflow=%b busy=%b, want 0 ffffffff 000 0",
                     bus.rf_wr, regs_sts, overflow, busy);
        end
        bus.rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_unit(0, 5'(21 + i), $urandom, 4'hF);
            set_unit(1, 5'(26 + i), $urandom, 4'hC);
            tick();
            clr_units();
        end
        n_checks++;
        if (overflow !== 3'b010 || regs_sts[21] !== 1'b0 || regs_sts[30] !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_state: overflow=%b sts21=%b sts30=%b, want 010 0 1", overflow, regs_sts[21], regs_sts[30]);
        end
        pulse_srst();
        n_checks++;
        if (bus.rf_wr !== 1'b0 || regs_sts !== {NREG{1'b1}} || overflow !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_clear: wr=%b regs_sts=%h overflow=%b busy=%b, want 0 ffffffff 000 0",
                     bus.rf_wr, regs_sts, overflow, busy);
        end
    endtask

    task automatic test_random();
        pulse_srst();
        for (int c = 0; c < 600; c++) begin
            clr_units();
            bus.rf_ready = ($urandom_range(0, 3) != 0);
            srst = ($urandom_range(0, 99) == 0);
            for (int u = 0; u < NU; u++)
                if ($urandom_range(0, 9) < 5)
                    set_unit(u, 5'($urandom_range(0, 31)), $urandom,
                             ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            if (c == 300) begin
                aresetn = 1'b0;
                #1;
                aresetn = 1'b1;
                model_clear();
                model_eval();
            end
            tick();
            n_checks++;
            if (bus.rf_wr !== exp_wr || (exp_wr && {bus.rf_addr, bus.rf_val, bus.rf_strb} !== exp_ent)) begin
                n_fail++;
                $display("FAIL random_port c=%0d: wr=%b addr=%0d val=%h strb=%h, want %b %0d %h %h",
                         c, bus.rf_wr, bus.rf_addr, bus.rf_val, bus.rf_strb, exp_wr, exp_ent.a, exp_ent.v, exp_ent.s);
            end
            n_checks++;
            if (regs_sts !== exp_regs || busy !== exp_busy || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_status c=%0d: regs_sts=%h busy=%b overflow=%b, want %h %b %b",
                         c, regs_sts, busy, overflow, exp_regs, exp_busy, m_ovf);
            end
        end
        srst = 1'b0;
        clr_units();
    endtask

    initial begin
        aresetn      = 1'b0;
        srst         = 1'b0;
        bus.rf_ready = 1'b0;
        clr_units();
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        aresetn = 1'b1;
        tick();
        test_single();
        test_contention();
        test_backpressure();
        test_overflow();
        test_push_while_full();
        test_filter_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/friscv_rd_wr_arbiter.md
Name: friscv_rd_wr_arbiter

Overview:
- Sits downstream of the processing stage's per-unit Rd write ports (ALU, memfy, M extension) and upstream of the ISA register file.
- Buffers each unit's write requests in a small per-unit FIFO.
- Round-robin arbitrates the FIFOs onto a single register-file write port with backpressure.
- Exports a per-register "no write pending" status vector, which the processing stage ANDs into its hazard-free check.

Parameters:
- XLEN, 32, register width (32 or 64).
- NB_UNIT, 3, number of unit write ports; legal range 1..4.
- FIFO_DEPTH, 4, entries per unit FIFO; power of two, at least 2.
- NB_INT_REG, 32, integer registers tracked; 16 when RV32E.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset.
- unit_rd_wr  in  NB_UNIT  per-unit write request, one cycle per write; no ready.
- unit_rd_addr  in  NB_UNIT*5  per-unit destination register.
- unit_rd_val  in  NB_UNIT*XLEN  per-unit write data.
- unit_rd_strb  in  NB_UNIT*XLEN/8  per-unit byte strobes.
- rf_wr  out  1  register-file write valid.
- rf_ready  in  1  register file accepts the write.
- rf_addr  out  5  register-file write address.
- rf_val  out  XLEN  register-file write data.
- rf_strb  out  XLEN/8  register-file byte strobes.
- regs_sts  out  NB_INT_REG  bit r = 1 when no buffered write targets register r.
- overflow  out  NB_UNIT  sticky per-unit overflow: a write was dropped because its FIFO was full.
- busy  out  1  any FIFO non-empty.

Behaviour:
- Clock aclk. Reset aresetn is asynchronous and active-low.
- Reset and srst both empty all FIFOs and clear all pointers.
  - Round-robin pointer goes to "last granted = NB_UNIT-1", so unit 0 has first priority.
  - overflow goes to 0.
  - Reset values: rf_wr=0, busy=0, regs_sts all ones.
  - Buffered entries are discarded on reset, including in-flight ones mid-operation.
- Push rule: a push occurs when unit_rd_wr[u]=1 and rd_addr != 0 and rd_strb != 0.
  - Writes to x0 and writes with all-zero strobes are discarded silently.
  - They do not set overflow.
- Push captures {addr, val, strb} into FIFO u on the clock edge. The entry becomes head-visible the next cycle.
- Latency, empty-FIFO case: a write presented in cycle N can appear on rf_* in cycle N+1 at the earliest. No combinational input-to-output path exists.
- Full FIFO without a pop in the same cycle: the write is dropped and overflow[u] is set. overflow clears only on reset or srst.
- Full FIFO with a pop of that FIFO in the same cycle: the push is accepted and nothing is dropped.
- Arbitration (combinational on FIFO heads):
  - Scan units starting at last_granted+1, wrapping modulo NB_UNIT.
  - The first non-empty FIFO is selected.
  - rf_wr = any head valid; rf_addr, rf_val and rf_strb come from the selected head.
- Handshake:
  - Pop occurs and last_granted updates only when rf_wr & rf_ready.
  - While rf_ready=0, rf_* stay stable, with the same selection, until accepted.
- One write per cycle maximum on rf_*.
- Ordering:
  - Within a unit, writes are in order.
  - Across units, no ordering is guaranteed. The upstream hazard logic must not issue an instruction whose rd, rs1 or rs2 has regs_sts=0.
- regs_sts[r] = NOR over all valid entries of all FIFOs of (entry.addr == r).
  - It is combinational from registered FIFO state.
  - It deasserts the cycle after the push.
  - It reasserts the cycle after the final pop of an entry targeting r.
- regs_sts[0] is always 1.
- busy = OR of all FIFO non-empty flags, registered-state only.
- For RV32E, rd_addr bit 4 is ignored when indexing regs_sts. Decode of such addresses is upstream's responsibility.

Decomposition:
- The shared package friscv_h gains the following, all reused by the processing stage:
  - RD_W (5).
  - An rd-entry packed struct {addr, val, strb} parameterised on XLEN via width macros.
  - A constant for the maximum unit count (4).
- One sub-module: friscv_rd_fifo.
  - Synchronous FIFO, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, head entry.
  - Also exposes a per-entry valid/addr array used to build regs_sts.
  - Instantiated NB_UNIT times in a generate loop.

Test Plan:
- Single write, unit 1 writes x5 = 0xDEADBEEF with strb 0xF, rf_ready=1 → in the next cycle rf_wr=1, rf_addr=5, rf_val=0xDEADBEEF; regs_sts[5]=0 for exactly that one cycle; busy then 0.
- Contention, all 3 units write in the same cycle to x1, x2, x3 with rf_ready=1 → grants in order unit0, unit1, unit2 over 3 consecutive cycles; a repeat burst continues the rotation from unit0.
- Backpressure, hold rf_ready=0 for 5 cycles with unit 0 pending → rf_addr and rf_val stay stable and no pop occurs; on release the entry is written once.
- Overflow, rf_ready=0 and 5 writes from unit 2 with FIFO_DEPTH=4 → overflow[2]=1; only the first 4 entries drain, in order.
- Push while full, FIFO full plus push and pop in the same cycle → no drop and overflow stays 0.
- Filtering and reset: a write to x0 and a write with strb=0 → no rf_wr and regs_sts unchanged; srst asserted with 3 entries buffered → FIFOs empty and rf_wr=0 next cycle, regs_sts all ones, overflow cleared.
